// File: rtl/conv_ctrl_param.sv
// conv_ctrl_param: sequencing FSM for a filter/slice convolution engine with live index counters.
// Defining CONV_CTRL_ABORT_EN adds an abort input and a one-cycle aborted pulse.
module conv_ctrl_param #(
    parameter int NUM_FILTERS   = 4,
    parameter int FILT_WORDS    = 4,
    parameter int SLICE_WORDS   = 16,
    parameter int BUF_ROWS      = 4,
    parameter int MAC_CYCLES    = 16,
    parameter int COLS          = 13,
    parameter int TOTAL_POS     = 43,
    parameter int RES_PER_WRITE = 4,
    parameter int IDX_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mem_ready,
`ifdef CONV_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic             ctrl_rst,
    output logic             inc_ld,
    output logic             adr_sel,
    output logic             filter_wr_en,
    output logic             img_wr_en,
    output logic             img_slice_en,
    output logic             acc_en,
    output logic             rst_acc,
    output logic             res_buffer_en,
    output logic             rst_res_reg,
    output logic             mem_wr_en,
    output logic             inc_en,
    output logic [1:0]       mem_offset_sel,
    output logic [IDX_W-1:0] filter_idx,
    output logic [IDX_W-1:0] word_idx,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] mac_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] pos_idx,
    output logic [IDX_W-1:0] reg_idx
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_INIT        = 4'd1;
    localparam logic [3:0] S_LD_FILTER   = 4'd2;
    localparam logic [3:0] S_NEXT_FILTER = 4'd3;
    localparam logic [3:0] S_LD_SLICE    = 4'd4;
    localparam logic [3:0] S_LD_BUFFER   = 4'd5;
    localparam logic [3:0] S_MAC         = 4'd6;
    localparam logic [3:0] S_LD_RESULT   = 4'd7;
    localparam logic [3:0] S_WRITE_MEM   = 4'd8;
    localparam logic [3:0] S_UPDATE      = 4'd9;
    localparam logic [3:0] S_INC_OFFSET  = 4'd10;
    localparam logic [3:0] S_DONE        = 4'd11;

    localparam logic [IDX_W-1:0] FILT_LAST  = IDX_W'(FILT_WORDS - 1);
    localparam logic [IDX_W-1:0] NF_LAST    = IDX_W'(NUM_FILTERS - 1);
    localparam logic [IDX_W-1:0] SLICE_LAST = IDX_W'(SLICE_WORDS - 1);
    localparam logic [IDX_W-1:0] ROW_LAST   = IDX_W'(BUF_ROWS - 1);
    localparam logic [IDX_W-1:0] MAC_LAST   = IDX_W'(MAC_CYCLES - 1);
    localparam logic [IDX_W-1:0] COL_LAST   = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] POS_LAST   = IDX_W'(TOTAL_POS - 1);
    localparam logic [IDX_W-1:0] REG_LAST   = IDX_W'(RES_PER_WRITE - 1);

    logic [3:0]       state, nxt;
    logic [IDX_W-1:0] filter_q, word_q, row_q, mac_q, col_q, pos_q, reg_q;
    logic             last_grp;
    logic             kill;
    logic             grp_full;

`ifdef CONV_CTRL_ABORT_EN
    logic aborted_q;
    assign kill = abort && (state != S_IDLE);
    always_ff @(posedge clk) begin
        if (rst) aborted_q <= 1'b0;
        else     aborted_q <= kill;
    end
    assign aborted = aborted_q && !rst;
`else
    assign kill = 1'b0;
`endif

    assign grp_full = (pos_q == POS_LAST) || (reg_q == REG_LAST);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:        if (start) nxt = S_INIT;
            S_INIT:        if (!start) nxt = S_LD_FILTER;
            S_LD_FILTER:   if (mem_ready && word_q == FILT_LAST) nxt = S_NEXT_FILTER;
            S_NEXT_FILTER: nxt = (filter_q == NF_LAST) ? S_LD_SLICE : S_LD_FILTER;
            S_LD_SLICE:    if (mem_ready && word_q == SLICE_LAST) nxt = S_LD_BUFFER;
            S_LD_BUFFER:   if (row_q == ROW_LAST) nxt = S_MAC;
            S_MAC:         if (mac_q == MAC_LAST) nxt = S_LD_RESULT;
            S_LD_RESULT:   nxt = grp_full ? S_WRITE_MEM : S_UPDATE;
            S_WRITE_MEM:   if (mem_ready) nxt = last_grp ? S_DONE : S_UPDATE;
            S_UPDATE:      nxt = (col_q == COL_LAST) ? S_INC_OFFSET : S_LD_BUFFER;
            S_INC_OFFSET:  nxt = S_LD_SLICE;
            S_DONE:        nxt = S_IDLE;
            default:       nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || kill || state == S_IDLE || state == S_INIT) begin
            state    <= (rst || kill) ? S_IDLE : nxt;
            filter_q <= '0;
            word_q   <= '0;
            row_q    <= '0;
            mac_q    <= '0;
            col_q    <= '0;
            pos_q    <= '0;
            reg_q    <= '0;
            last_grp <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                S_LD_FILTER:   if (mem_ready) word_q <= word_q + 1'b1;
                S_NEXT_FILTER: begin
                    word_q   <= '0;
                    filter_q <= filter_q + 1'b1;
                end
                S_LD_SLICE:    if (mem_ready) word_q <= (word_q == SLICE_LAST) ? '0 : word_q + 1'b1;
                S_LD_BUFFER:   row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                S_MAC:         mac_q <= (mac_q == MAC_LAST) ? '0 : mac_q + 1'b1;
                S_LD_RESULT: begin
                    pos_q <= pos_q + 1'b1;
                    // reg_idx names the slot just filled, so it holds while that group is written
                    if (!grp_full) reg_q <= reg_q + 1'b1;
                    if (pos_q == POS_LAST) last_grp <= 1'b1;
                end
                S_WRITE_MEM:   if (mem_ready) reg_q <= '0;
                S_UPDATE:      col_q <= col_q + 1'b1;
                S_INC_OFFSET:  col_q <= '0;
                default: ;
            endcase
        end
    end

    // Every output is forced low while reset is held, even mid-run.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        ctrl_rst       = 1'b0;
        inc_ld         = 1'b0;
        adr_sel        = 1'b0;
        filter_wr_en   = 1'b0;
        img_wr_en      = 1'b0;
        img_slice_en   = 1'b0;
        acc_en         = 1'b0;
        rst_acc        = 1'b0;
        res_buffer_en  = 1'b0;
        rst_res_reg    = 1'b0;
        mem_wr_en      = 1'b0;
        inc_en         = 1'b0;
        mem_offset_sel = 2'd0;
        if (!rst) begin
            busy = (state != S_IDLE);
            case (state)
                S_INIT: begin
                    ctrl_rst = 1'b1;
                    inc_ld   = 1'b1;
                end
                S_LD_FILTER: begin
                    adr_sel      = 1'b1;
                    filter_wr_en = mem_ready;
                end
                S_LD_SLICE: begin
                    mem_offset_sel = 2'd1;
                    img_wr_en      = mem_ready;
                end
                S_LD_BUFFER: img_slice_en = 1'b1;
                S_MAC:       acc_en = 1'b1;
                S_LD_RESULT: begin
                    res_buffer_en = 1'b1;
                    rst_acc       = 1'b1;
                end
                S_WRITE_MEM: begin
                    mem_offset_sel = 2'd2;
                    mem_wr_en      = mem_ready;
                    rst_res_reg    = mem_ready;
                end
                S_INC_OFFSET: inc_en = 1'b1;
                S_DONE:       done = 1'b1;
                default: ;
            endcase
        end
    end

    assign filter_idx = rst ? '0 : filter_q;
    assign word_idx   = rst ? '0 : word_q;
    assign row_idx    = rst ? '0 : row_q;
    assign mac_idx    = rst ? '0 : mac_q;
    assign col_idx    = rst ? '0 : col_q;
    assign pos_idx    = rst ? '0 : pos_q;
    assign reg_idx    = rst ? '0 : reg_q;

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Directed bench for conv_ctrl_param: strobe totals, memory stall, partial final write, reset and start hold.
module tb_conv_ctrl_param;

    localparam int TOTAL_POS = 43;
    localparam int RPW       = 4;
    localparam int IDX_W     = 8;
    localparam int LIMIT     = 5000;

    logic clk = 1'b0;
    logic rst, start, mem_ready;
    logic busy, done, ctrl_rst, inc_ld, adr_sel, filter_wr_en, img_wr_en, img_slice_en;
    logic acc_en, rst_acc, res_buffer_en, rst_res_reg, mem_wr_en, inc_en;
    logic [1:0] mem_offset_sel;
    logic [IDX_W-1:0] filter_idx, word_idx, row_idx, mac_idx, col_idx, pos_idx, reg_idx;
    logic [71:0] all_out;

    conv_ctrl_param #(
        .NUM_FILTERS(4), .FILT_WORDS(4), .SLICE_WORDS(16), .BUF_ROWS(4), .MAC_CYCLES(16),
        .COLS(13), .TOTAL_POS(TOTAL_POS), .RES_PER_WRITE(RPW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
        .busy(busy), .done(done), .ctrl_rst(ctrl_rst), .inc_ld(inc_ld),
        .adr_sel(adr_sel), .filter_wr_en(filter_wr_en), .img_wr_en(img_wr_en),
        .img_slice_en(img_slice_en), .acc_en(acc_en), .rst_acc(rst_acc),
        .res_buffer_en(res_buffer_en), .rst_res_reg(rst_res_reg), .mem_wr_en(mem_wr_en),
        .inc_en(inc_en), .mem_offset_sel(mem_offset_sel),
        .filter_idx(filter_idx), .word_idx(word_idx), .row_idx(row_idx), .mac_idx(mac_idx),
        .col_idx(col_idx), .pos_idx(pos_idx), .reg_idx(reg_idx)
    );

    assign all_out = {busy, done, ctrl_rst, inc_ld, adr_sel, filter_wr_en, img_wr_en,
                      img_slice_en, acc_en, rst_acc, res_buffer_en, rst_res_reg, mem_wr_en,
                      inc_en, mem_offset_sel, filter_idx, word_idx, row_idx, mac_idx,
                      col_idx, pos_idx, reg_idx};

    always #5 clk = ~clk;

    typedef struct {
        int reg_i;
        int pos_i;
    } wr_t;
    wr_t sb[$];

    int n_checks = 0;
    int n_err    = 0;
    int cnt_fw, cnt_img, cnt_res, cnt_acc, cnt_wr, cnt_inc, cnt_done;
    logic prev_wr = 1'b0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected memory writes of one run: a write closes every full group and the final partial one.
    task automatic push_run();
        wr_t e;
        for (int p = 0; p < TOTAL_POS; p++) begin
            if ((p % RPW) == RPW - 1 || p == TOTAL_POS - 1) begin
                e.reg_i = p % RPW;
                e.pos_i = p + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic clear_counts();
        cnt_fw = 0; cnt_img = 0; cnt_res = 0; cnt_acc = 0;
        cnt_wr = 0; cnt_inc = 0; cnt_done = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cnt_fw   += int'(filter_wr_en);
            cnt_img  += int'(img_wr_en);
            cnt_res  += int'(res_buffer_en);
            cnt_acc  += int'(acc_en);
            cnt_wr   += int'(mem_wr_en);
            cnt_inc  += int'(inc_en);
            cnt_done += int'(done);
            if (mem_wr_en) begin
                wr_t e;
                chk("sb_nonempty", 72'(sb.size() != 0), 72'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_reg_idx", 72'(reg_idx), 72'(e.reg_i));
                    chk("wr_pos_idx", 72'(pos_idx), 72'(e.pos_i));
                end
            end
            if (done) begin
                chk("done_after_write", 72'(prev_wr), 72'd1);
                chk("sb_empty_at_done", 72'(sb.size()), 72'd0);
            end
            prev_wr = mem_wr_en;
        end
    end

    task automatic wait_done();
        for (int c = 0; c < LIMIT; c++) begin
            @(posedge clk); #1;
            if (cnt_done != 0) break;
        end
        chk("done_count", 72'(cnt_done), 72'd1);
        @(posedge clk); #1;
        chk("idle_after_done", 72'(busy), 72'd0);
    endtask

    task automatic check_totals();
        chk("filter_wr_en_total", 72'(cnt_fw), 72'd16);
        chk("img_wr_en_total", 72'(cnt_img), 72'd64);
        chk("res_buffer_en_total", 72'(cnt_res), 72'd43);
        chk("acc_en_total", 72'(cnt_acc), 72'd688);
        chk("mem_wr_en_total", 72'(cnt_wr), 72'd11);
        chk("inc_en_total", 72'(cnt_inc), 72'd3);
    endtask

    initial begin
        logic found;
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("outputs_in_reset", all_out, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", all_out, '0);

        // Run 1: single start pulse, memory always ready.
        clear_counts();
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_totals();

        // Run 2: start held three cycles, then a five-cycle stall on filter word 2.
        clear_counts();
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        chk("init_hold_c1", 72'({ctrl_rst, inc_ld, busy}), 72'b111);
        @(posedge clk); #1;
        chk("init_hold_c2", 72'({ctrl_rst, inc_ld, busy}), 72'b111);
        @(posedge clk); #1;
        start = 1'b0;
        chk("init_hold_c3", 72'({ctrl_rst, inc_ld, busy}), 72'b111);
        @(posedge clk); #1;
        chk("ld_filter_entry", 72'({adr_sel, mem_offset_sel, filter_wr_en, ctrl_rst}), 72'b10010);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (adr_sel && filter_idx == 0 && word_idx == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_word2", 72'(found), 72'd1);
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                @(posedge clk); #1;
            end
            #0;
            chk("stall_filter_wr_en", 72'(filter_wr_en), 72'd0);
            chk("stall_word_idx", 72'(word_idx), 72'd2);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        wait_done();
        check_totals();

        // Run 3: reset pulse in the middle of MAC, then a fresh run.
        clear_counts();
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            @(posedge clk); #1;
            if (acc_en && mac_idx == 7) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_mac7", 72'(found), 72'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("outputs_during_midrun_rst", all_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_after_midrun_rst", all_out, '0);
        repeat (30) @(posedge clk);
        #1;
        chk("still_idle_after_rst", all_out, '0);
        chk("no_done_after_rst", 72'(cnt_done), 72'd0);

        clear_counts();
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_totals();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
